hdmi_packet_scheduler: RTL

//  Parametrised HDMI data-island packet scheduler for the clk_pixel domain.

---
 rtl/hdmi_packet_scheduler_if.sv | 39 +++
 rtl/hdmi_packet_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_packet_scheduler_if.sv
// Scheduler bus: field/packet timing, ACR tick and audio input towards the
// scheduler, packet selection, audio payload and status flags back out.
interface hdmi_packet_scheduler_if #(
    parameter int CHANNELS        = 2,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int NUM_INFOFRAMES  = 5
);
    logic                                video_field_end;
    logic                                packet_enable;
    logic [4:0]                          packet_pixel_counter;
    logic                                acr_tick;
    logic                                sample_valid;
    logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_data;
    logic [7:0]                          packet_type;
    logic [191:0]                        audio_packet_data;
    logic [3:0]                          audio_packet_present;
    logic                                audio_packet_layout;
    logic [7:0]                          frame_counter;
    logic                                fifo_overflow;
    logic [NUM_INFOFRAMES-1:0]           infoframe_missed;
    logic [15:0]                         drop_count;
    logic [15:0]                         miss_count;

    modport master (
        output video_field_end, packet_enable, packet_pixel_counter,
        output acr_tick, sample_valid, sample_data,
        input  packet_type, audio_packet_data, audio_packet_present,
        input  audio_packet_layout, frame_counter, fifo_overflow,
        input  infoframe_missed, drop_count, miss_count
    );

    modport slave (
        input  video_field_end, packet_enable, packet_pixel_counter,
        input  acr_tick, sample_valid, sample_data,
        output packet_type, audio_packet_data, audio_packet_present,
        output audio_packet_layout, frame_counter, fifo_overflow,
        output infoframe_missed, drop_count, miss_count
    );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island packet scheduler (clk_pixel domain): audio frame FIFO,
// ACR > audio > InfoFrame > null arbitration on each packet_enable.
// Ports: clk_pixel, reset_n (async active-low), bus (slave modport) carrying
// timing/audio inputs and packet_type, audio payload and status outputs.
// Optional HDMI_PACKET_SCHEDULER_STATS_EN adds saturating drop/miss counters.
module hdmi_packet_scheduler #(
    parameter int                          CHANNELS         = 2,
    parameter int                          AUDIO_BIT_WIDTH  = 16,
    parameter int                          FIFO_DEPTH       = 8,
    parameter int                          NUM_INFOFRAMES   = 5,
    parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES  = 40'h84_82_83_7F_81,
    parameter int                          INFOFRAME_PERIOD = 1
) (
    input logic                    clk_pixel,
    input logic                    reset_n,
    hdmi_packet_scheduler_if.slave bus
);
    localparam int   FPP    = (CHANNELS == 8) ? 1 : 4;
    localparam logic LAYOUT = (CHANNELS == 8);
    localparam int   FW     = CHANNELS * AUDIO_BIT_WIDTH;
    localparam int   AW     = $clog2(FIFO_DEPTH);
    localparam int   LW     = AW + 1;

    localparam logic [7:0] PT_NULL  = 8'h00;
    localparam logic [7:0] PT_ACR   = 8'h01;
    localparam logic [7:0] PT_AUDIO = 8'h02;

    logic [FW-1:0] fifo_mem [FIFO_DEPTH];

    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]             level_q, level_d;
    logic                      acr_pending_q, acr_pending_d;
    logic [7:0]                packet_type_q, packet_type_d;
    logic [191:0]              audio_data_q, audio_data_d;
    logic [3:0]                present_q, present_d;
    logic                      layout_q, layout_d;
    logic [7:0]                frame_cnt_q, frame_cnt_d;
    logic                      overflow_q, overflow_d;
    // Slot i lives at bit NUM_INFOFRAMES-1-i, matching the type-code order.
    logic [NUM_INFOFRAMES-1:0] sent_q, sent_d;
    logic [NUM_INFOFRAMES-1:0] missed_q, missed_d;
    logic                      win_q, win_d;

    logic                      push, pop, drop, full;
    logic                      acr_req, audio_req;
    logic                      grant_acr, grant_audio, grant_slot;
    logic                      slot_hit;
    logic [7:0]                slot_type;
    logic [NUM_INFOFRAMES-1:0] slot_oh;
    logic                      win_close;
    logic [FW-1:0]             frame;

    function automatic logic [23:0] ljust(input logic [AUDIO_BIT_WIDTH-1:0] s);
        logic [23:0] r;
        r = '0;
        r[23 -: AUDIO_BIT_WIDTH] = s;
        return r;
    endfunction

    always_comb begin
        full      = (level_q == LW'(FIFO_DEPTH));
        push      = bus.sample_valid & ~full;
        drop      = bus.sample_valid & full;
        // A tick arriving with packet_enable is served in that same slot.
        acr_req   = acr_pending_q | bus.acr_tick;
        audio_req = (level_q >= LW'(FPP));

        slot_hit  = 1'b0;
        slot_type = PT_NULL;
        slot_oh   = '0;
        // Highest unsent bit is the lowest-numbered slot; last hit wins.
        for (int b = 0; b < NUM_INFOFRAMES; b++) begin
            if (!sent_q[b]) begin
                slot_hit   = 1'b1;
                slot_type  = INFOFRAME_TYPES[b*8 +: 8];
                slot_oh    = '0;
                slot_oh[b] = 1'b1;
            end
        end

        grant_acr     = 1'b0;
        grant_audio   = 1'b0;
        grant_slot    = 1'b0;
        packet_type_d = packet_type_q;
        if (bus.packet_enable) begin
            if (bus.video_field_end) begin
                packet_type_d = PT_NULL;
            end else if (acr_req) begin
                grant_acr     = 1'b1;
                packet_type_d = PT_ACR;
            end else if (audio_req) begin
                grant_audio   = 1'b1;
                packet_type_d = PT_AUDIO;
            end else if (slot_hit) begin
                grant_slot    = 1'b1;
                packet_type_d = slot_type;
            end else begin
                packet_type_d = PT_NULL;
            end
        end
        pop = grant_audio;

        if (grant_acr) begin
            // Only a tick that found ACR already pending survives the grant.
            acr_pending_d = acr_pending_q & bus.acr_tick;
        end else begin
            acr_pending_d = acr_pending_q | bus.acr_tick;
        end

        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(FPP) : AW'(0));
        level_d  = level_q + (push ? LW'(1) : LW'(0))
                           - (pop ? LW'(FPP) : LW'(0));
        overflow_d = overflow_q | drop;

        // Frame f, channel c lands at 24-bit lane f*CHANNELS+c; this covers
        // both layouts (4 stereo frames, or one 8-channel frame).
        frame        = '0;
        audio_data_d = audio_data_q;
        present_d    = present_q;
        layout_d     = layout_q;
        if (grant_audio) begin
            audio_data_d = '0;
            present_d    = 4'hF;
            layout_d     = LAYOUT;
            for (int f = 0; f < FPP; f++) begin
                frame = fifo_mem[rd_ptr_q + AW'(f)];
                for (int c = 0; c < CHANNELS; c++) begin
                    audio_data_d[(f*CHANNELS+c)*24 +: 24] =
                        ljust(frame[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
                end
            end
        end

        frame_cnt_d = frame_cnt_q;
        if (bus.packet_pixel_counter == 5'd31 && packet_type_q == PT_AUDIO) begin
            if (frame_cnt_q >= 8'(192 - FPP)) begin
                frame_cnt_d = frame_cnt_q - 8'(192 - FPP);
            end else begin
                frame_cnt_d = frame_cnt_q + 8'(FPP);
            end
        end

        win_close = 1'b0;
        win_d     = win_q;
        if (bus.video_field_end) begin
            if (win_q == 1'(INFOFRAME_PERIOD - 1)) begin
                win_close = 1'b1;
                win_d     = 1'b0;
            end else begin
                win_d = ~win_q;
            end
        end

        sent_d   = sent_q;
        missed_d = missed_q;
        if (grant_slot) begin
            sent_d = sent_q | slot_oh;
        end
        if (win_close) begin
            missed_d = missed_q | ~sent_q;
            sent_d   = '0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.sample_data;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            acr_pending_q <= 1'b0;
            packet_type_q <= '0;
            audio_data_q  <= '0;
            present_q     <= '0;
            layout_q      <= 1'b0;
            frame_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            sent_q        <= '0;
            missed_q      <= '0;
            win_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            acr_pending_q <= acr_pending_d;
            packet_type_q <= packet_type_d;
            audio_data_q  <= audio_data_d;
            present_q     <= present_d;
            layout_q      <= layout_d;
            frame_cnt_q   <= frame_cnt_d;
            overflow_q    <= overflow_d;
            sent_q        <= sent_d;
            missed_q      <= missed_d;
            win_q         <= win_d;
        end
    end

    assign bus.packet_type          = packet_type_q;
    assign bus.audio_packet_data    = audio_data_q;
    assign bus.audio_packet_present = present_q;
    assign bus.audio_packet_layout  = layout_q;
    assign bus.frame_counter        = frame_cnt_q;
    assign bus.fifo_overflow        = overflow_q;
    assign bus.infoframe_missed     = missed_q;

`ifdef HDMI_PACKET_SCHEDULER_STATS_EN
    logic [15:0] drop_count_q, drop_count_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic [4:0]  miss_num;
    logic [16:0] miss_sum;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        miss_num = '0;
        for (int b = 0; b < NUM_INFOFRAMES; b++) begin
            if (!sent_q[b]) begin
                miss_num = miss_num + 5'd1;
            end
        end
        miss_sum     = {1'b0, miss_count_q} + 17'(miss_num);
        miss_count_d = miss_count_q;
        if (win_close) begin
            miss_count_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
            miss_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.drop_count = drop_count_q;
    assign bus.miss_count = miss_count_q;
`else
    assign bus.drop_count = '0;
    assign bus.miss_count = '0;
`endif
endmodule
